// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access sequencer in front of Data_Memory.
// Port A (MEM stage) and port B (secondary master) issue req/ack transactions.
// The winner's we/addr/wdata are registered and drive the memory for one
// ACCESS cycle; completion and read data return in the following RESP cycle.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   port A request, direction, address, store data
//   a_rdata/a_ack/a_err         port A load data, completion pulse, error
//   b_*                         same as port A, for port B
//   mem_addr/mem_wdata          memory address and write data
//   mem_write/mem_read          memory strobes, asserted only in ACCESS
//   mem_rdata                   memory read data (combinational in mem_addr)
//   busy                        high whenever the sequencer is not idle
//
// Build option: define DMEM_ARB_FAIR_EN to bound port B's wait under
// contention to MAX_WAIT lost arbitrations; otherwise port A always wins.

module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [63:0] a_addr,
  input  logic [63:0] a_wdata,
  output logic [63:0] a_rdata,
  output logic        a_ack,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [63:0] b_addr,
  input  logic [63:0] b_wdata,
  output logic [63:0] b_rdata,
  output logic        b_ack,
  output logic        b_err,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned AW = 64;
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_BYTES - 8);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          grant;
  logic          grant_b;
  logic          force_b;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [AW-1:0] sel_wdata;
  logic          sel_err;

  logic          owner_q;   // 0: port A, 1: port B
  logic          we_q;
  logic          err_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] wdata_q;
  logic [AW-1:0] a_rdata_q;
  logic [AW-1:0] b_rdata_q;
  logic          a_ack_q;
  logic          b_ack_q;
  logic          a_err_q;
  logic          b_err_q;
  logic          rd_q;
  logic          wr_q;
  logic          busy_q;

`ifdef DMEM_ARB_FAIR_EN
  localparam int unsigned WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [WW-1:0] wait_q;

  // Port B is forced through once it has lost MAX_WAIT contested rounds.
  assign force_b = (wait_q == WW'(MAX_WAIT));

  // Count contested rounds lost by port B; any grant to B restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= '0;
    end else if (grant) begin
      if (grant_b) begin
        wait_q <= '0;
      end else if (b_req) begin
        wait_q <= wait_q + WW'(1);
      end
    end
  end
`else
  // Fixed priority: port B is never forced (MAX_WAIT matters only in fair mode).
  assign force_b = 1'b0 & (MAX_WAIT == 0);
`endif

  // Winner's request fields and its address check.
  assign sel_we    = grant_b ? b_we    : a_we;
  assign sel_addr  = grant_b ? b_addr  : a_addr;
  assign sel_wdata = grant_b ? b_wdata : a_wdata;
  assign sel_err   = (sel_addr > LAST_ADDR) || (sel_addr[2:0] != 3'b000);

  // Next-state and grant decision; requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    grant_b = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          grant   = 1'b1;
          grant_b = b_req && (!a_req || force_b);
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;

      if (grant) begin
        owner_q <= grant_b;
        we_q    <= sel_we;
        err_q   <= sel_err;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        // Strobes for the coming ACCESS cycle; an illegal address gets none.
        wr_q    <= sel_we && !sel_err;
        rd_q    <= !sel_we && !sel_err;
      end

      // Closing edge of ACCESS: capture load data and raise the owner's ack.
      if (state_q == ACCESS) begin
        if (owner_q) begin
          b_ack_q <= 1'b1;
          b_err_q <= err_q;
          if (err_q) begin
            b_rdata_q <= '0;
          end else if (!we_q) begin
            b_rdata_q <= mem_rdata;
          end
        end else begin
          a_ack_q <= 1'b1;
          a_err_q <= err_q;
          if (err_q) begin
            a_rdata_q <= '0;
          end else if (!we_q) begin
            a_rdata_q <= mem_rdata;
          end
        end
      end
    end
  end

  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_err     = a_err_q;
  assign b_err     = b_err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

  // Reset gates the strobes so an interrupted ACCESS never commits.
  assign mem_write = wr_q && !reset;
  assign mem_read  = rd_q && !reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic on both
// ports, checked every cycle against a transaction-level model that schedules
// each grant's ACCESS/ack cycles arithmetically and keeps its own memory image.
`timescale 1ns/1ps

module tb_dmem_arbiter;

  localparam int unsigned MEM_BYTES = 256;
  localparam int unsigned MAX_WAIT  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [63:0] a_addr = '0, a_wdata = '0;
  logic [63:0] a_rdata;
  logic        a_ack, a_err;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [63:0] b_addr = '0, b_wdata = '0;
  logic [63:0] b_rdata;
  logic        b_ack, b_err;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ack(a_ack), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack), .b_err(b_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Data_Memory stand-in: little-endian bytes, combinational read, write on edge.
  logic [7:0] env_mem [MEM_BYTES];
  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = env_mem[8'(mem_addr[7:0] + 8'(i))];
  end
  always @(posedge clk) begin
    if (mem_write) begin
      for (int i = 0; i < 8; i++) env_mem[8'(mem_addr[7:0] + 8'(i))] <= mem_wdata[8*i +: 8];
    end
  end

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [MEM_BYTES];
  int          cyc = 0;
  bit          chk_en = 1'b0;
  bit          g_valid = 1'b0;
  int          g_cyc = 0;
  bit          g_port = 1'b0;
  bit          g_we = 1'b0;
  bit          g_err = 1'b0;
  logic [63:0] g_addr = '0, g_wdata = '0;
  logic [63:0] m_maddr = '0, m_mwdata = '0;
  logic [63:0] m_rd [2];
  int          m_wait = 0;
  bit          saw_mw = 1'b0;

  function automatic logic [63:0] ref_rd(input logic [63:0] ad);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[8'(ad[7:0] + 8'(i))];
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_write) saw_mw = 1'b1;

  // A grant sampled in cycle g gives the memory cycle at g+1 and the ack at g+2.
  always @(negedge clk) begin
    bit in_acc, in_resp, win_b;
    in_acc  = g_valid && (cyc == g_cyc + 1);
    in_resp = g_valid && (cyc == g_cyc + 2);
    if (in_acc) begin
      m_maddr  = g_addr;
      m_mwdata = g_wdata;
    end
    if (in_resp) begin
      if (g_err) m_rd[g_port] = '0;
      else if (!g_we) m_rd[g_port] = ref_rd(g_addr);
    end
    if (chk_en) begin
      chk1("busy", busy, in_acc || in_resp);
      chk1("mem_write", mem_write, in_acc && g_we && !g_err && !reset);
      chk1("mem_read", mem_read, in_acc && !g_we && !g_err && !reset);
      chk64("mem_addr", mem_addr, m_maddr);
      chk64("mem_wdata", mem_wdata, m_mwdata);
      chk1("a_ack", a_ack, in_resp && !g_port);
      chk1("b_ack", b_ack, in_resp && g_port);
      chk64("a_rdata", a_rdata, m_rd[0]);
      chk64("b_rdata", b_rdata, m_rd[1]);
      if (in_resp) chk1(g_port ? "b_err" : "a_err", g_port ? b_err : a_err, g_err);
    end
    if (reset) begin
      g_valid  = 1'b0;
      m_maddr  = '0;
      m_mwdata = '0;
      m_rd[0]  = '0;
      m_rd[1]  = '0;
      m_wait   = 0;
    end else begin
      if (in_acc && g_we && !g_err) begin
        for (int i = 0; i < 8; i++) ref_mem[8'(g_addr[7:0] + 8'(i))] = g_wdata[8*i +: 8];
      end
      if (in_resp) g_valid = 1'b0;
      if (!in_acc && !in_resp && (a_req || b_req)) begin
        if (a_req && b_req) begin
`ifdef DMEM_ARB_FAIR_EN
          win_b = (m_wait == MAX_WAIT);
          if (!win_b) m_wait++;
`else
          win_b = 1'b0;
`endif
        end else begin
          win_b = b_req;
        end
        if (win_b) m_wait = 0;
        g_valid = 1'b1;
        g_cyc   = cyc;
        g_port  = win_b;
        g_we    = win_b ? b_we : a_we;
        g_addr  = win_b ? b_addr : a_addr;
        g_wdata = win_b ? b_wdata : a_wdata;
        g_err   = (g_addr > 64'(MEM_BYTES - 8)) || (g_addr[2:0] != 3'b000);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from the current cycle and wait (bounded) for its ack.
  task automatic txn(input bit port, input bit we, input logic [63:0] addr,
                     input logic [63:0] wd, output logic [63:0] rd,
                     output bit er, output int lat);
    bit done;
    done = 1'b0; lat = 0; rd = '0; er = 1'b0;
    if (port) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    while (!done && lat < 20) begin
      @(negedge clk);
      if (port ? b_ack : a_ack) begin
        done = 1'b1;
        rd = port ? b_rdata : a_rdata;
        er = port ? b_err : a_err;
      end
      tick();
      if (!done) lat++;
    end
    chk1("txn_completed", done, 1'b1);
    if (port) b_req = 1'b0; else a_req = 1'b0;
  endtask

  task automatic rand_req(output logic we, output logic [63:0] ad, output logic [63:0] wd);
    int kind;
    kind = $urandom_range(0, 9);
    we = 1'($urandom_range(0, 1));
    if (kind < 6)       ad = 64'($urandom_range(0, 31)) << 3;
    else if (kind < 8)  ad = 64'($urandom_range(0, 255));
    else if (kind == 8) ad = 64'(MEM_BYTES - 8) + 64'($urandom_range(1, 16));
    else                ad = {32'($urandom), 32'($urandom)} | 64'h1_0000_0000;
    wd = {32'($urandom), 32'($urandom)};
  endtask

  initial begin
    logic [63:0] rd;
    bit          er;
    int          lat, n_arb, diffs;
    bit          ad, bd;
    logic [6:0]  a_pat, b_pat, bz_pat;
    logic [15:0] win;

    for (int j = 0; j < MEM_BYTES; j++) begin
      env_mem[j] = (j % 8 == 0) ? 8'(j / 8) : 8'h00;
      ref_mem[j] = env_mem[j];
    end
    m_rd[0] = '0;
    m_rd[1] = '0;

    repeat (3) tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    chk64("reset_a_rdata", a_rdata, 64'h0);
    chk1("reset_busy", busy, 1'b0);

    // Fresh image: doubleword at 0x08 holds 1.
    txn(1'b1, 1'b0, 64'h08, 64'h0, rd, er, lat);
    chk64("b_load8_data", rd, 64'h1);
    chk1("b_load8_err", er, 1'b0);
    chk64("b_load8_latency", 64'(lat), 64'd2);

    txn(1'b0, 1'b1, 64'h10, 64'h1122334455667788, rd, er, lat);
    chk64("a_store_latency", 64'(lat), 64'd2);
    chk64("a_store_bytes", {env_mem[8'h17], env_mem[8'h16], env_mem[8'h15], env_mem[8'h14],
                            env_mem[8'h13], env_mem[8'h12], env_mem[8'h11], env_mem[8'h10]},
          64'h1122334455667788);
    txn(1'b0, 1'b0, 64'h10, 64'h0, rd, er, lat);
    chk64("a_load10_data", rd, 64'h1122334455667788);

    // Illegal addresses: error, zero data, no write strobe, memory untouched.
    saw_mw = 1'b0;
    txn(1'b0, 1'b0, 64'hFC, 64'h0, rd, er, lat);
    chk1("err_load_fc_err", er, 1'b1);
    chk64("err_load_fc_data", rd, 64'h0);
    txn(1'b0, 1'b1, 64'h03, 64'hDEADBEEFCAFEF00D, rd, er, lat);
    chk1("err_store_03_err", er, 1'b1);
    chk64("err_store_03_data", rd, 64'h0);
    chk1("err_no_mem_write", saw_mw, 1'b0);
    chk64("err_mem_00", {env_mem[8'h07], env_mem[8'h06], env_mem[8'h05], env_mem[8'h04],
                         env_mem[8'h03], env_mem[8'h02], env_mem[8'h01], env_mem[8'h00]}, 64'h0);
    chk64("err_mem_08", {env_mem[8'h0F], env_mem[8'h0E], env_mem[8'h0D], env_mem[8'h0C],
                         env_mem[8'h0B], env_mem[8'h0A], env_mem[8'h09], env_mem[8'h08]}, 64'h1);
    chk64("err_mem_f8", {env_mem[8'hFF], env_mem[8'hFE], env_mem[8'hFD], env_mem[8'hFC],
                         env_mem[8'hFB], env_mem[8'hFA], env_mem[8'hF9], env_mem[8'hF8]}, 64'h1F);

    // Simultaneous requests: A acks at n+2, B at n+5, one idle cycle at n+3.
    a_req = 1'b1; a_we = 1'b0; a_addr = 64'h18;
    b_req = 1'b1; b_we = 1'b0; b_addr = 64'h20;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      a_pat[k] = a_ack; b_pat[k] = b_ack; bz_pat[k] = busy;
      ad = a_ack; bd = b_ack;
      tick();
      if (ad) a_req = 1'b0;
      if (bd) b_req = 1'b0;
    end
    a_req = 1'b0; b_req = 1'b0;
    chk64("both_a_ack_pattern", 64'(a_pat), 64'b000_0100);
    chk64("both_b_ack_pattern", 64'(b_pat), 64'b010_0000);
    chk64("both_busy_pattern", 64'(bz_pat), 64'b011_0110);
    chk64("both_b_rdata", b_rdata, 64'h4);
    repeat (2) tick();

    // Reset during the ACCESS cycle of a store: no strobe, no ack, all zero after.
    a_req = 1'b1; a_we = 1'b1; a_addr = 64'h20; a_wdata = 64'hA5A5A5A5A5A5A5A5;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk1("rst_acc_busy", busy, 1'b1);
    chk1("rst_acc_no_write", mem_write, 1'b0);
    tick();
    reset = 1'b0; a_req = 1'b0;
    @(negedge clk);
    chk1("rst_after_ack", a_ack, 1'b0);
    chk1("rst_after_busy", busy, 1'b0);
    chk64("rst_after_a_rdata", a_rdata, 64'h0);
    chk64("rst_after_b_rdata", b_rdata, 64'h0);
    chk64("rst_after_mem_addr", mem_addr, 64'h0);
    chk64("rst_after_mem_wdata", mem_wdata, 64'h0);
    chk64("rst_mem_20_kept", {env_mem[8'h27], env_mem[8'h26], env_mem[8'h25], env_mem[8'h24],
                              env_mem[8'h23], env_mem[8'h22], env_mem[8'h21], env_mem[8'h20]}, 64'h4);
    tick();

    // Continuous port A pressure with port B waiting.
    a_req = 1'b1; a_we = 1'b0; a_addr = 64'h28;
    b_req = 1'b1; b_we = 1'b0; b_addr = 64'h30;
    win = '0; n_arb = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ad = a_ack; bd = b_ack;
      if ((ad || bd) && n_arb < 16) begin
        win[n_arb] = bd;
        n_arb++;
      end
      tick();
      if (bd) b_req = 1'b0;
      else if (!b_req) b_req = 1'b1;
    end
    a_req = 1'b0; b_req = 1'b0;
    chk64("fair_arb_count", 64'(n_arb), 64'd13);
`ifdef DMEM_ARB_FAIR_EN
    chk64("fair_winners", 64'(win[10:0]), 64'b100_0001_0000);
`else
    chk64("fixed_winners", 64'(win[12:0]), 64'h0);
`endif
    repeat (5) tick();

    // Randomized traffic on both ports.
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      ad = a_ack; bd = b_ack;
      tick();
      if (a_req) begin
        if (ad) a_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        rand_req(a_we, a_addr, a_wdata);
        a_req = 1'b1;
      end
      if (b_req) begin
        if (bd) b_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        rand_req(b_we, b_addr, b_wdata);
        b_req = 1'b1;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (6) tick();

    diffs = 0;
    for (int j = 0; j < MEM_BYTES; j++) if (env_mem[j] !== ref_mem[j]) diffs++;
    chk64("final_memory_diff_bytes", 64'(diffs), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of `Data_Memory`, the 256-byte, byte-addressed, little-endian doubleword store. Sits between the MEM stage (port A) and a secondary master such as the debug/DMA loader (port B). Drives the memory's address, data and strobes from registered copies of the winning request. Returns read data and completion through a req/ack handshake.

## Interface
Parameters:
- `MEM_BYTES`, 256: memory size in bytes; legal doubleword addresses are 0..MEM_BYTES-8.
- `MAX_WAIT`, 4: lost arbitrations port B tolerates before it is forced to win (fair mode only).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `a_req`  in  1  port A request; held high until `a_ack`.
- `a_we`  in  1  port A: 1 = store, 0 = load.
- `a_addr`  in  64  port A byte address.
- `a_wdata`  in  64  port A store data.
- `a_rdata`  out  64  port A load data; valid while `a_ack` = 1.
- `a_ack`  out  1  port A one-cycle completion pulse.
- `a_err`  out  1  port A error, valid with `a_ack`.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_rdata`, `b_ack`, `b_err`: same as port A, for port B.
- `mem_addr`  out  64  to `Data_Memory.Mem_Addr`.
- `mem_wdata`  out  64  to `Data_Memory.Write_Data`.
- `mem_write`  out  1  to `MemWrite`.
- `mem_read`  out  1  to `MemRead`.
- `mem_rdata`  in  64  from `Read_Data`; combinational in `mem_addr`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM has three states.
  - IDLE: sample `a_req`/`b_req`. If either is high, latch the winner's `we`, `addr` and `wdata`, record the owner and the error flag, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS (1 cycle): drive `mem_addr`/`mem_wdata` from the latched values. Assert `mem_write` (store) or `mem_read` (load). On the closing edge, a store commits inside `Data_Memory` and a load captures `mem_rdata` into the owner's rdata register. Then go to RESP.
  - RESP (1 cycle): pulse the owner's `ack`, with `err` and `rdata` held. Requests are not sampled in this state. Then return to IDLE.
- Requester protocol:
  - A requester drops `req` in the cycle after its `ack`.
  - `we`/`addr`/`wdata` only need to be stable in the IDLE cycle in which they are sampled.
- Arbitration (default): port A has fixed priority when both ports request.
- Error condition: `addr` > MEM_BYTES-8, or `addr[2:0]` != 0.
  - In ACCESS, `mem_read` and `mem_write` stay 0, so memory is untouched.
  - In RESP, `err` = 1 and `rdata` = 0.
- The non-owner's `rdata` holds its previous value.
- `mem_addr`/`mem_wdata` hold their last values outside ACCESS; strobes are 0 outside ACCESS.
- Reset:
  - FSM returns to IDLE.
  - All outputs = 0, including `a_rdata`/`b_rdata`, both `ack`, both `err`, strobes, `mem_addr`, `mem_wdata` and `busy`.
  - Wait counter = 0.
  - Reset mid-ACCESS suppresses the strobe on the reset edge and drops the transaction; no `ack` is issued.

## Timing
- Request seen high in IDLE at cycle n gives ACCESS at n+1 and `ack` at n+2. Read data is valid during n+2.
- Peak throughput is one access per 3 cycles.
- A request arriving while `busy` waits. Earliest service starts in the IDLE cycle after RESP.
- Both ports requesting: winner finishes at n+2; loser is sampled at n+3, reaches ACCESS at n+4 and gets `ack` at n+5.
- No combinational path from any `req` to any `mem_*` output or `ack`.

## Configuration
- `DMEM_ARB_FAIR_EN` defined:
  - A wait counter (width clog2(MAX_WAIT+1)) increments on each IDLE arbitration where port A wins while `b_req` = 1.
  - When the counter equals MAX_WAIT, the next arbitration with `b_req` = 1 goes to port B even if `a_req` = 1.
  - The counter clears whenever port B is granted.
- Undefined: no counter; port A always wins. Port B can starve under continuous `a_req`.

## Test plan
- Port A store 0x1122334455667788 @0x10 at cycle n, then load @0x10: `a_ack` at n+2; load returns 0x1122334455667788. Bytes 0x10..0x17 in memory = 88,77,...,11.
- Port B load @0x08 on a fresh memory image: `b_ack` 2 cycles after the request is sampled; `b_rdata` = 1; `b_err` = 0.
- `a_req` and `b_req` rise together: `a_ack` at n+2, `b_ack` at n+5. `busy` stays high except the IDLE cycle at n+3.
- Port A load @0xFC, then store @0x03: each gets `a_err` = 1 with `a_ack`, `a_rdata` = 0 and `mem_write` never asserted. Memory is unchanged.
- `DMEM_ARB_FAIR_EN`, MAX_WAIT = 4, `a_req` held continuously with `b_req` high: port A wins 4 times, then port B wins the 5th arbitration, then the counter restarts from 0. Without the macro, `b_ack` never asserts.
- `reset` asserted in an ACCESS cycle of a store @0x20: no write occurs, no `ack`; the FSM is in IDLE and all outputs are 0 on the next cycle.
